// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register.
//   MODE_*   : 2-bit mode encodings driven on the M port
//   state_t  : burst sequencer state encoding
//   is_shift_mode() : true for the two modes a burst can run in
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic is_shift_mode(input logic [1:0] m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/univ_shift_reg_mux_4to1.sv
// One-bit 4:1 mode mux used per bit of the universal shift register.
// Ports:
//   sel : 2-bit select (00 -> a, 01 -> b, 10 -> c, 11 -> d)
//   a   : hold candidate (current bit)
//   b   : shift-right candidate
//   c   : shift-left candidate
//   d   : parallel-load candidate
//   y   : selected next-state bit
module mux_4to1
  import shift_reg_pkg::*;
(
  input  logic [1:0] sel,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic       y
);

  always_comb begin
    y = a;
    unique case (sel)
      MODE_HOLD: y = a;
      MODE_SHR:  y = b;
      MODE_SHL:  y = c;
      MODE_LOAD: y = d;
      default:   y = a;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with a burst-shift sequencer.
// Each bit has a 4:1 mode mux (hold / right / left / load) whose output is
// registered every clk edge. A start pulse in IDLE with a shift mode runs a
// burst of `count` shifts in the latched direction.
//
// Optional feature macro: ROTATE_EN
//   defined   -> extra input rot; rot=1 makes shifts rotate and ignores the
//                serial inputs (sampled every cycle, also during a burst)
//   undefined -> no rot port; shifts always take the serial inputs
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous reset, active low
//   M         : mode (00 hold, 01 shift right, 10 shift left, 11 load)
//   par_in    : parallel load data
//   ser_in_r  : serial in, enters Q[WIDTH-1] on a right shift
//   ser_in_l  : serial in, enters Q[0] on a left shift
//   start     : burst request (IDLE with M=01/10 only)
//   count     : burst length, sampled with start
//   rot       : rotate enable (ROTATE_EN only)
//   Q         : register contents
//   ser_out_r : Q[0]
//   ser_out_l : Q[WIDTH-1]
//   busy      : high while a burst is running
//   done      : one-cycle pulse when a burst ends
//
// Sequencer states:
//   state   | meaning
//   ST_IDLE | M drives the muxes directly; start may launch a burst
//   ST_RUN  | burst in progress; latched direction drives the muxes
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       M,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
`ifdef ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [1:0]       dir_q;
  logic [CNT_W-1:0] rem_q;
  logic [WIDTH-1:0] q_q;
  logic             busy_q;
  logic             done_q;

  logic [1:0]       mode_eff;
  logic [WIDTH-1:0] q_next;
  logic             start_shift;
  logic             rot_eff;
  logic             msb_in;
  logic             lsb_in;

`ifdef ROTATE_EN
  assign rot_eff = rot;
`else
  assign rot_eff = 1'b0;
`endif

  // Bits shifted in at the ends: wrap-around when rotating, serial otherwise.
  assign msb_in = rot_eff ? q_q[0]       : ser_in_r;
  assign lsb_in = rot_eff ? q_q[WIDTH-1] : ser_in_l;

  assign start_shift = start && is_shift_mode(M);

  // A zero-length burst request must not shift, so it forces hold.
  always_comb begin
    mode_eff = M;
    if (state_q == ST_RUN) begin
      mode_eff = dir_q;
    end else if (start_shift && (count == '0)) begin
      mode_eff = MODE_HOLD;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic right_nb;
    logic left_nb;

    if (i == WIDTH-1) begin : g_msb
      assign right_nb = msb_in;
    end else begin : g_mid_r
      assign right_nb = q_q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign left_nb = lsb_in;
    end else begin : g_mid_l
      assign left_nb = q_q[i-1];
    end

    mux_4to1 u_mux (
      .sel (mode_eff),
      .a   (q_q[i]),
      .b   (right_nb),
      .c   (left_nb),
      .d   (par_in[i]),
      .y   (q_next[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      state_q <= ST_IDLE;
      dir_q   <= MODE_HOLD;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      q_q    <= q_next;
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_shift) begin
            if (count == '0) begin
              done_q <= 1'b1;
            end else begin
              dir_q <= M;
              rem_q <= count - CNT_ONE;
              if (count == CNT_ONE) begin
                done_q <= 1'b1;
              end else begin
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          rem_q <= rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Q         = q_q;
  assign ser_out_r = q_q[0];
  assign ser_out_l = q_q[WIDTH-1];
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, CNT_W=4).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_univ_shift_reg;

  logic       clk;
  logic       rst_n;
  logic [1:0] M;
  logic [7:0] par_in;
  logic       ser_in_r;
  logic       ser_in_l;
  logic       start;
  logic [3:0] count;
`ifdef ROTATE_EN
  logic       rot;
`endif
  logic [7:0] Q;
  logic       ser_out_r;
  logic       ser_out_l;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .M         (M),
    .par_in    (par_in),
    .ser_in_r  (ser_in_r),
    .ser_in_l  (ser_in_l),
    .start     (start),
    .count     (count),
`ifdef ROTATE_EN
    .rot       (rot),
`endif
    .Q         (Q),
    .ser_out_r (ser_out_r),
    .ser_out_l (ser_out_l),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    chk({tag, "_q"}, {24'd0, Q}, {24'd0, eq});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, ed});
  endtask

  // busy and done must never be high together
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
    end
  end

  initial begin
    rst_n = 1'b0; M = 2'b00; par_in = 8'h00; ser_in_r = 1'b0; ser_in_l = 1'b0;
    start = 1'b0; count = 4'd0;
`ifdef ROTATE_EN
    rot = 1'b0;
`endif
    #3 rst_n = 1'b1;

    // 1: async reset with Q=FF, no clock edge
    M = 2'b11; par_in = 8'hFF;
    step();
    chk("load_ff", {24'd0, Q}, 32'hFF);
    rst_n = 1'b0;
    #1;
    chk_st("async_rst", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    // 2: parallel load then hold for 3 cycles
    M = 2'b11; par_in = 8'hA5;
    step();
    chk("load_a5", {24'd0, Q}, 32'hA5);
    M = 2'b00; par_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_a5", {24'd0, Q}, 32'hA5);
    end

    // 3: single right and left shifts
    M = 2'b11; par_in = 8'h81;
    step();
    chk("ser_out_r_81", {31'd0, ser_out_r}, 32'd1);
    chk("ser_out_l_81", {31'd0, ser_out_l}, 32'd1);
    M = 2'b01; ser_in_r = 1'b0;
    step();
    chk("shr_81", {24'd0, Q}, 32'h40);
    chk("ser_out_l_40", {31'd0, ser_out_l}, 32'd0);
    M = 2'b11; par_in = 8'h81;
    step();
    M = 2'b10; ser_in_l = 1'b1;
    step();
    chk("shl_81", {24'd0, Q}, 32'h03);

    // 4: burst of 3 left shifts, M=11 ignored during RUN
    M = 2'b11; par_in = 8'hF0;
    step();
    start = 1'b1; M = 2'b10; count = 4'd3; ser_in_l = 1'b0;
    step();
    chk_st("burst3_e1", 8'hE0, 1'b1, 1'b0);
    start = 1'b0; M = 2'b11; par_in = 8'h00; count = 4'd0;
    step();
    chk_st("burst3_e2", 8'hC0, 1'b1, 1'b0);
    step();
    chk_st("burst3_e3", 8'h80, 1'b0, 1'b1);
    M = 2'b00;
    step();
    chk_st("burst3_after", 8'h80, 1'b0, 1'b0);

    // 5: zero-length burst, then back-to-back start in the done cycle
    start = 1'b1; M = 2'b01; count = 4'd0; ser_in_r = 1'b1;
    step();
    chk_st("cnt0", 8'h80, 1'b0, 1'b1);
    count = 4'd2;
    step();
    chk_st("b2b_e1", 8'hC0, 1'b1, 1'b0);
    start = 1'b0; M = 2'b00; count = 4'd0;
    step();
    chk_st("b2b_e2", 8'hE0, 1'b0, 1'b1);
    step();
    chk_st("b2b_after", 8'hE0, 1'b0, 1'b0);

    // count=1 burst: single shift, immediate done, never busy
    start = 1'b1; M = 2'b10; count = 4'd1; ser_in_l = 1'b1;
    step();
    chk_st("cnt1", 8'hC1, 1'b0, 1'b1);
    // start with M=11 is ignored; load acts normally
    M = 2'b11; par_in = 8'h5A; count = 4'd3;
    step();
    chk_st("start_load", 8'h5A, 1'b0, 1'b0);
    start = 1'b0;

    // 6: reset mid-burst
    start = 1'b1; M = 2'b01; count = 4'd5; ser_in_r = 1'b0;
    step();
    chk_st("abort_e1", 8'h2D, 1'b1, 1'b0);
    start = 1'b0; M = 2'b00; count = 4'd0;
    step();
    chk_st("abort_e2", 8'h16, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_st("abort_rst", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_st("abort_post1", 8'h00, 1'b0, 1'b0);
    step();
    chk_st("abort_post2", 8'h00, 1'b0, 1'b0);

`ifdef ROTATE_EN
    M = 2'b11; par_in = 8'h01;
    step();
    rot = 1'b1; M = 2'b01; ser_in_r = 1'b0;
    step();
    chk("rot_right", {24'd0, Q}, 32'h80);
    M = 2'b10; ser_in_l = 1'b0;
    step();
    chk("rot_left", {24'd0, Q}, 32'h01);
    rot = 1'b0; M = 2'b00;
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
